// File: rtl/execute_muldiv.sv
// execute_muldiv: EX stage with forwarding, ALU, next-PC select and an iterative RV32M multiply/divide unit
module execute_muldiv #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      JumpE,
   input  logic            BranchE,
   input  logic [3:0]      ALUControlE,
   input  logic            ALUSrcAE,
   input  logic            ALUSrcBE,
   input  logic [2:0]      BranchTypeE,
   input  logic            MulDivE,
   input  logic [2:0]      MulDivOpE,
   input  logic            FlushE,
   input  logic [XLEN-1:0] ResultW,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [1:0]      PCSrcE,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            StallMDE
);
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(XLEN);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

   logic [XLEN-1:0]   fa, fb, srca, srcb, alu_out, res, nres, bmag, amag_in, bmag_in, quo, rem;
   logic [2*XLEN-1:0] acc, nacc, prod;
   logic [1:0]        state;
   logic [CW-1:0]     count;
   logic [2:0]        op;
   logic              neg_p, neg_r, divz, take, sa, sb;

   assign fa         = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
   assign fb         = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
   assign WriteDataE = fb;
   assign srca       = ALUSrcAE ? PCE : fa;
   assign srcb       = ALUSrcBE ? ImmExtE : fb;
   assign PCTargetE  = PCE + ImmExtE;

   // ALU operation select
   always_comb begin
      case (ALUControlE)
         4'b0000: alu_out = srca + srcb;
         4'b0001: alu_out = srca - srcb;
         4'b0010: alu_out = srca & srcb;
         4'b0011: alu_out = srca | srcb;
         4'b0100: alu_out = srca ^ srcb;
         4'b0101: alu_out = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
         4'b0110: alu_out = {{(XLEN-1){1'b0}}, srca < srcb};
         4'b0111: alu_out = srca << srcb[SW-1:0];
         4'b1000: alu_out = srca >> srcb[SW-1:0];
         4'b1001: alu_out = $signed(srca) >>> srcb[SW-1:0];
         4'b1010: alu_out = srcb;
         default: alu_out = '0;
      endcase
   end

   // branch condition on the forwarded register operands
   always_comb begin
      case (BranchTypeE)
         3'b000:  take = fa == fb;
         3'b001:  take = fa != fb;
         3'b100:  take = $signed(fa) < $signed(fb);
         3'b101:  take = $signed(fa) >= $signed(fb);
         3'b110:  take = fa < fb;
         3'b111:  take = fa >= fb;
         default: take = 1'b0;
      endcase
   end

   assign PCSrcE = JumpE == 2'b10 ? 2'b10 : (JumpE == 2'b01 || (BranchE && take)) ? 2'b01 : 2'b00;

   // MUL keeps the signed view; its low half is identical either way
   assign sa      = fa[XLEN-1] & (MulDivOpE[2] ? ~MulDivOpE[0] : MulDivOpE[1:0] != 2'b11);
   assign sb      = fb[XLEN-1] & (MulDivOpE[2] ? ~MulDivOpE[0] : ~MulDivOpE[1]);
   assign amag_in = sa ? -fa : fa;
   assign bmag_in = sb ? -fb : fb;

   // one bit of shift-add multiply (acc = {partial high, multiplier}) or restoring divide (acc = {remainder, quotient})
   function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] p, input logic [XLEN-1:0] d, input logic div);
      logic [XLEN:0] t;
      logic          ge;
      t  = div ? {p[2*XLEN-1:XLEN], p[XLEN-1]} : {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, d} : '0);
      ge = t >= {1'b0, d};
      return div ? {ge ? t[XLEN-1:0] - d : t[XLEN-1:0], p[XLEN-2:0], ge} : {t, p[XLEN-1:1]};
   endfunction

   // retire BITS_PER_CYCLE bits per iteration
   always_comb begin
      nacc = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) nacc = step(nacc, bmag, op[2]);
   end

   assign prod = neg_p ? -nacc : nacc;
   assign quo  = divz ? '1 : neg_p ? -nacc[XLEN-1:0] : nacc[XLEN-1:0];
   assign rem  = neg_r ? -nacc[2*XLEN-1:XLEN] : nacc[2*XLEN-1:XLEN];
   assign nres = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

   // IDLE -> BUSY (latch operands) -> DONE (hold result) -> IDLE; flush aborts from any state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         op    <= '0;
         acc   <= '0;
         bmag  <= '0;
         res   <= '0;
         neg_p <= 1'b0;
         neg_r <= 1'b0;
         divz  <= 1'b0;
      end else if (FlushE) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: if (MulDivE) begin
               state <= BUSY;
               count <= '0;
               op    <= MulDivOpE;
               acc   <= {{XLEN{1'b0}}, amag_in};
               bmag  <= bmag_in;
               neg_p <= sa ^ sb;
               neg_r <= sa;
               divz  <= fb == '0;
            end
            BUSY: begin
               acc   <= nacc;
               count <= count + CW'(1);
               if (count == CW'(N-1)) begin
                  state <= DONE;
                  res   <= nres;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign StallMDE   = rst_n & ~FlushE & ((state == IDLE & MulDivE) | state == BUSY);
   assign ALUResultE = state == DONE ? res : alu_out;
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: randomized self-checking bench for the EX stage with multiply/divide
module tb_execute_muldiv;
   localparam int XLEN = 32;
   localparam int N    = 32;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [1:0]      JumpE = '0, ForwardAE = '0, ForwardBE = '0, PCSrcE;
   logic            BranchE = 1'b0, ALUSrcAE = 1'b0, ALUSrcBE = 1'b0, MulDivE = 1'b0, FlushE = 1'b0, StallMDE;
   logic [3:0]      ALUControlE = '0;
   logic [2:0]      BranchTypeE = '0, MulDivOpE = '0;
   logic [XLEN-1:0] ResultW = '0, ALUResultM = '0, RD1E = '0, RD2E = '0, PCE = '0, ImmExtE = '0;
   logic [XLEN-1:0] WriteDataE, ALUResultE, PCTargetE;
   int              checks = 0, failures = 0;

   execute_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .BranchTypeE(BranchTypeE), .MulDivE(MulDivE),
      .MulDivOpE(MulDivOpE), .FlushE(FlushE), .ResultW(ResultW), .ALUResultM(ALUResultM),
      .RD1E(RD1E), .RD2E(RD2E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCE(PCE),
      .ImmExtE(ImmExtE), .WriteDataE(WriteDataE), .PCSrcE(PCSrcE), .ALUResultE(ALUResultE),
      .PCTargetE(PCTargetE), .StallMDE(StallMDE)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference RV32M results from 64-bit integer arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = $signed(a);
      longint          sb = $signed(b);
      longint unsigned ua = {32'b0, a};
      longint unsigned ub = {32'b0, b};
      longint          ps;
      longint unsigned pu;
      case (op)
         3'd0: begin ps = sa * sb; return ps[31:0]; end
         3'd1: begin ps = sa * sb; return ps[63:32]; end
         3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
         3'd3: begin pu = ua * ub; return pu[63:32]; end
         3'd4: begin ps = sa / (b == 0 ? 64'sd1 : sb); return b == 0 ? 32'hFFFFFFFF : ps[31:0]; end
         3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
         3'd6: begin ps = sa % (b == 0 ? 64'sd1 : sb); return b == 0 ? a : ps[31:0]; end
         default: return b == 0 ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic go_idle_add(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      MulDivE = 1'b0; FlushE = 1'b0; ALUControlE = 4'b0000; ALUSrcAE = 1'b0; ALUSrcBE = 1'b0;
      ForwardAE = 2'b00; ForwardBE = 2'b00; RD1E = a; RD2E = b; BranchE = 1'b0; JumpE = 2'b00;
   endtask

   task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noisy);
      logic [1:0] s_a, s_b;
      @(negedge clk);
      s_a = noisy ? 2'($urandom_range(0, 3)) : 2'b00;
      s_b = noisy ? 2'($urandom_range(0, 3)) : 2'b00;
      if ((s_a == 2'b01 || s_a == 2'b10) && s_b == s_a && a != b) s_b = 2'b00;
      ResultW = $urandom; ALUResultM = $urandom; RD1E = $urandom; RD2E = $urandom;
      PCE = $urandom; ImmExtE = $urandom; ALUSrcAE = noisy; ALUSrcBE = noisy;
      case (s_a) 2'b01: ResultW = a; 2'b10: ALUResultM = a; default: RD1E = a; endcase
      case (s_b) 2'b01: ResultW = b; 2'b10: ALUResultM = b; default: RD2E = b; endcase
      ForwardAE = s_a; ForwardBE = s_b; MulDivE = 1'b1; MulDivOpE = op;
      BranchE = 1'b0; JumpE = 2'b00; FlushE = 1'b0; ALUControlE = 4'b0000;
   endtask

   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noisy,
                         output logic [31:0] res, output int stalls);
      start_md(op, a, b, noisy);
      stalls = 0;
      #1;
      while (StallMDE && stalls < 200) begin
         stalls++;
         @(negedge clk);
         if (noisy) begin
            ResultW = $urandom; ALUResultM = $urandom; RD1E = $urandom; RD2E = $urandom;
            ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
         end
         #1;
      end
      res = ALUResultE;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; MulDivE = 1'b1; RD1E = 32'd3; RD2E = 32'd4;
      #1;
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", StallMDE); end
      checks++; if (ALUResultE !== 32'd7) begin failures++; $display("FAIL reset_alu: got %h expected %h", ALUResultE, 32'd7); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; MulDivE = 1'b0;
   endtask

   task automatic test_alu();
      logic [31:0] ea, eb, sa, sb;
      go_idle_add(32'd99, 32'd7);
      ForwardAE = 2'b10; ALUResultM = 32'd5;
      #1;
      checks++; if (ALUResultE !== 32'd12) begin failures++; $display("FAIL alu_fwd_add: got %h expected %h", ALUResultE, 32'd12); end
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b expected 0", StallMDE); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ALUResultM = $urandom; PCE = $urandom; ImmExtE = $urandom;
         ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
         ALUSrcAE = 1'($urandom_range(0, 1)); ALUSrcBE = 1'($urandom_range(0, 1));
         ea = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
         eb = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
         sa = ALUSrcAE ? PCE : ea;
         sb = ALUSrcBE ? ImmExtE : eb;
         #1;
         checks++; if (ALUResultE !== sa + sb) begin failures++; $display("FAIL alu_rand_add: got %h expected %h", ALUResultE, sa + sb); end
         checks++; if (WriteDataE !== eb) begin failures++; $display("FAIL writedata: got %h expected %h", WriteDataE, eb); end
         checks++; if (PCTargetE !== PCE + ImmExtE) begin failures++; $display("FAIL pctarget: got %h expected %h", PCTargetE, PCE + ImmExtE); end
      end
   endtask

   task automatic test_mul();
      logic [31:0] r;
      int          s;
      run_md(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, r, s);
      checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_7x-3: got %h expected FFFFFFEB", r); end
      checks++; if (s !== N + 1) begin failures++; $display("FAIL mul_latency: got %0d expected %0d", s, N + 1); end
      checks++; if (PCSrcE !== 2'b00) begin failures++; $display("FAIL mul_pcsrc: got %b expected 00", PCSrcE); end
      go_idle_add(32'd1, 32'd2);
      #1;
      checks++; if (StallMDE !== 1'b0 || ALUResultE !== 32'd3) begin failures++; $display("FAIL mul_then_idle: got stall=%b res=%h expected stall=0 res=3", StallMDE, ALUResultE); end
      run_md(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, s);
      checks++; if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu_max: got %h expected FFFFFFFE", r); end
      run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, s);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL mulh_-1x-1: got %h expected 00000000", r); end
   endtask

   task automatic test_div();
      logic [2:0]  ops [7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
      logic [31:0] as  [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
      logic [31:0] bs  [7] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
      logic [31:0] exs [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFF};
      logic [31:0] r;
      int          s;
      for (int i = 0; i < 7; i++) begin
         run_md(ops[i], as[i], bs[i], 1'b0, r, s);
         checks++; if (r !== exs[i]) begin failures++; $display("FAIL div_case%0d op=%0d: got %h expected %h", i, ops[i], r, exs[i]); end
         checks++; if (s !== N + 1) begin failures++; $display("FAIL div_latency%0d: got %0d expected %0d", i, s, N + 1); end
      end
   endtask

   task automatic test_random(input bit noisy, input int count);
      logic [2:0]  op;
      logic [31:0] a, b, r;
      int          s;
      for (int i = 0; i < count; i++) begin
         op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
         run_md(op, a, b, noisy, r, s);
         checks++; if (r !== ref_md(op, a, b)) begin failures++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h expected %h", noisy, op, a, b, r, ref_md(op, a, b)); end
         checks++; if (s !== N + 1) begin failures++; $display("FAIL rand_latency: got %0d expected %0d", s, N + 1); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2;
      int          s1, s2;
      run_md(3'd0, 32'd1000, 32'd1000, 1'b0, r1, s1);
      run_md(3'd5, 32'd1000, 32'd3, 1'b0, r2, s2);
      checks++; if (r1 !== 32'd1000000) begin failures++; $display("FAIL b2b_first: got %h expected %h", r1, 32'd1000000); end
      checks++; if (r2 !== 32'd333 || s2 !== N + 1) begin failures++; $display("FAIL b2b_second: got %h/%0d expected %h/%0d", r2, s2, 32'd333, N + 1); end
   endtask

   task automatic test_flush();
      logic [31:0] r;
      int          s;
      start_md(3'd0, 32'd123, 32'd456, 1'b0);
      #1;
      for (int k = 1; k <= 11; k++) begin @(negedge clk); #1; end
      checks++; if (StallMDE !== 1'b1) begin failures++; $display("FAIL flush_busy: got %b expected 1", StallMDE); end
      FlushE = 1'b1;
      #1;
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", StallMDE); end
      go_idle_add(32'd1, 32'd2);
      #1;
      checks++; if (StallMDE !== 1'b0 || ALUResultE !== 32'd3) begin failures++; $display("FAIL flush_idle: got stall=%b res=%h expected stall=0 res=3", StallMDE, ALUResultE); end
      start_md(3'd0, 32'd5, 32'd6, 1'b0);
      FlushE = 1'b1;
      #1;
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL flush_prio: got %b expected 0", StallMDE); end
      go_idle_add(32'd4, 32'd5);
      #1;
      checks++; if (StallMDE !== 1'b0 || ALUResultE !== 32'd9) begin failures++; $display("FAIL flush_nostart: got stall=%b res=%h expected stall=0 res=9", StallMDE, ALUResultE); end
      run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, s);
      checks++; if (r !== 32'hFFFFFFFF || s !== N + 1) begin failures++; $display("FAIL flush_after_mulhsu: got %h/%0d expected FFFFFFFF/%0d", r, s, N + 1); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r;
      int          s;
      start_md(3'd4, 32'd1000, 32'd9, 1'b0);
      #1;
      for (int k = 1; k <= 6; k++) begin @(negedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %b expected 0", StallMDE); end
      @(negedge clk);
      rst_n = 1'b1; MulDivE = 1'b0;
      #1;
      checks++; if (StallMDE !== 1'b0) begin failures++; $display("FAIL rst_release_stall: got %b expected 0", StallMDE); end
      run_md(3'd5, 32'd100, 32'd7, 1'b0, r, s);
      checks++; if (r !== 32'd14) begin failures++; $display("FAIL rst_divu: got %h expected %h", r, 32'd14); end
      checks++; if (s !== N + 1) begin failures++; $display("FAIL rst_divu_latency: got %0d expected %0d", s, N + 1); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mul();
      test_div();
      test_random(1'b0, 30);
      test_random(1'b1, 12);
      test_back_to_back();
      test_flush();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Parametrised EX stage for the pipelined core. It keeps the existing forwarding muxes, alu and pcsrc_unit path and adds an iterative RV32M multiply/divide unit, which stalls the front end through the hazard unit while it runs. Instructions other than multiply/divide complete in one cycle, exactly as in the current EX stage.

Parameters:
XLEN, 32, datapath width for every data/address port and for the multiply/divide operands.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal values are 1, 2 and 4, and the value must divide XLEN. N = XLEN/BITS_PER_CYCLE.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
JumpE  in  2  jump type, passed to pcsrc_unit
BranchE  in  1  branch instruction in EX
ALUControlE  in  4  ALU operation select
ALUSrcAE  in  1  1: SrcA = PCE
ALUSrcBE  in  1  1: SrcB = ImmExtE
BranchTypeE  in  3  branch condition select
MulDivE  in  1  instruction in EX is an M-extension op
MulDivOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
FlushE  in  1  EX flush from the hazard unit; aborts an in-flight operation
ResultW  in  XLEN  WB forwarding value
ALUResultM  in  XLEN  MEM forwarding value
RD1E  in  XLEN  register-file operand 1
RD2E  in  XLEN  register-file operand 2
ForwardAE  in  2  00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E
ForwardBE  in  2  same encoding for operand 2
PCE  in  XLEN  PC of the EX instruction
ImmExtE  in  XLEN  extended immediate
WriteDataE  out  XLEN  forwarded operand 2
PCSrcE  out  2  next-PC select from pcsrc_unit
ALUResultE  out  XLEN  ALU result, or mul/div result in DONE
PCTargetE  out  XLEN  PCE + ImmExtE, wraps modulo 2^XLEN
StallMDE  out  1  1: stall F/D/E and bubble M this cycle

Behaviour:
- Non-MulDiv path: purely combinational; forwarding, SrcA/SrcB muxing, PCTargetE, WriteDataE and PCSrcE are identical to the current EX stage.
- FSM states: IDLE, BUSY, DONE. Reset (async, rst_n=0) forces IDLE, clears the counter, operand and result registers, and drives StallMDE=0. Reset mid-operation discards the operation.
- IDLE with MulDivE=1 and FlushE=0:
  - StallMDE=1 combinationally.
  - On the next edge, capture the forwarded operands (post-ForwardAE/BE, never ImmExtE/PCE) and MulDivOpE, then go to BUSY with count=0.
  - Operands are latched because the M/W forwarding sources change while EX is stalled.
- BUSY: StallMDE=1. Each cycle retires BITS_PER_CYCLE bits and increments count. At count=N-1, go to DONE.
- DONE: StallMDE=0; ALUResultE = registered result; the pipeline advances. On the next edge return to IDLE unconditionally. MulDivE=1 in DONE never restarts the operation.
- Latency: a mul/div occupies EX for N+2 cycles, with StallMDE high for N+1 of them. Back-to-back mul/div ops are independent; the second starts from IDLE.
- Signedness: operands are sign-corrected to magnitudes, the unsigned shift-add or restoring division runs on the magnitudes, and the sign is corrected after.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits of the 2*XLEN product.
- Division by zero: quotient = all ones (DIV and DIVU); remainder = dividend. No trap.
- Signed overflow (DIV/REM, dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
- FlushE=1 in any state: return to IDLE next edge, StallMDE=0 in that cycle; FlushE has priority over MulDivE.
- When MulDivE=1, the decoder guarantees BranchE=0 and JumpE=00, so PCSrcE=00.

Test Plan:
- ADD with ForwardAE=10, ALUResultM=5, RD2E=7 -> ALUResultE=12 combinationally; StallMDE stays 0.
- MUL 7 * -3, BITS_PER_CYCLE=1 -> StallMDE high for 33 cycles; DONE shows ALUResultE=0xFFFFFFEB; IDLE on the following cycle.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULH -1 * -1 -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIV 0x80000000/-1 -> 0x80000000 with REM -> 0.
- Change ResultW/ALUResultM every cycle during BUSY -> result unaffected. Assert FlushE at count 10 -> IDLE next cycle, StallMDE=0.
- Deassert rst_n at count 5 -> StallMDE=0 immediately. After release, a new DIVU 100/7 -> 14, with the full N+2 latency.
